// File: rtl/ro_meas_pkg.sv
// ----------------------------------------------------------------------------
// ro_meas_pkg
// Shared definitions for the ring-oscillator measurement blocks.
//   - meas_state_t : measurement FSM state encoding
//   - DEF_*        : default widths / settle length
//   - cnt_w()      : width needed to hold a down-counter loaded with n-1
// ----------------------------------------------------------------------------
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_t;

    localparam int DEF_COUNT_W       = 16;
    localparam int DEF_GATE_W        = 16;
    localparam int DEF_SETTLE_CYCLES = 8;

    // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
// Brings an asynchronous level into the clk domain through two flops and
// emits a one-cycle pulse on each synchronized rising transition.
//   clk      : in  1  sampling clock
//   rst_n    : in  1  asynchronous active-low reset (all flops clear to 0)
//   async_in : in  1  asynchronous input level
//   rise     : out 1  one-cycle pulse, 2-3 clk cycles after async_in rises
// Inputs toggling faster than clk/2 alias; nothing here detects that.
// ----------------------------------------------------------------------------
module sync_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic history;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            history <= 1'b0;
        end else begin
            sync_1  <= async_in;
            sync_2  <= sync_1;
            history <= sync_2;
        end
    end

    // sync_1 may be metastable; only sync_2 and history feed logic.
    assign rise = sync_2 & ~history;

endmodule

// File: rtl/ro_freq_counter.sv
// ----------------------------------------------------------------------------
// ro_freq_counter
// Measures a ring oscillator against clk: enable the oscillator, let it
// settle for SETTLE_CYCLES, count its synchronized rising edges over a
// gate window of gate_len clk cycles, then disable it and report.
//
// Parameters:
//   COUNT_W       : width of the edge count result
//   GATE_W        : width of gate_len
//   SETTLE_CYCLES : clk cycles the oscillator runs before counting (>= 1)
// Ports:
//   clk       : in  1        system clock
//   rst_n     : in  1        asynchronous active-low reset
//   start     : in  1        level-sampled request, honoured only in IDLE
//   abort     : in  1        cancel during SETTLE/MEASURE (no done pulse)
//   gate_len  : in  GATE_W   window length, captured on accepted start
//   ro_clk    : in  1        oscillator output, asynchronous to clk
//   ro_en     : out 1        oscillator enable (SETTLE, MEASURE)
//   busy      : out 1        high in SETTLE and MEASURE
//   done      : out 1        one-cycle pulse when count/overflow are new
//   count     : out COUNT_W  last completed result, held until next done
//   overflow  : out 1        last result saturated
//   dbg_state : out 2        current FSM state (meas_state_t encoding)
//
// Request/response: start is a level, accepted on any cycle where the FSM
// is IDLE and start=1; there is no ready signal, busy says a request would be
// ignored. Each accepted start ends in exactly one of: a done pulse (result
// registers updated in that same cycle), an abort, or a reset.
// ----------------------------------------------------------------------------
module ro_freq_counter
    import ro_meas_pkg::*;
#(
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int GATE_W        = DEF_GATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic               ro_clk,
    output logic               ro_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic [1:0]         dbg_state
);

    localparam int                    SETTLE_W    = cnt_w(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0]   SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0]    COUNT_MAX   = '1;

    meas_state_t         state;
    meas_state_t         state_next;

    logic [SETTLE_W-1:0] settle_cnt;
    logic [GATE_W-1:0]   gate_cap;
    logic [GATE_W-1:0]   gate_cnt;
    logic [COUNT_W-1:0]  acc;
    logic                acc_ovf;
    logic [COUNT_W-1:0]  acc_next;
    logic                acc_ovf_next;

    logic                edge_p;
    logic                accept;
    logic                load_gate;
    logic                result_ld;

    // ------------------------------------------------------------------
    // Oscillator edge detection
    // ------------------------------------------------------------------
    sync_rise_detect u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ro_clk),
        .rise     (edge_p)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_gate  = 1'b0;
        result_ld  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    if (gate_cap == '0) begin
                        // Empty window: report the freshly cleared accumulator.
                        result_ld  = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        load_gate  = 1'b1;
                        state_next = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                // abort wins over gate expiry in the same cycle.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (gate_cnt == GATE_W'(1)) begin
                    result_ld  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating accumulator. The value including this cycle's edge is
    // what gets reported, so the last MEASURE cycle's edge is counted.
    // ------------------------------------------------------------------
    always_comb begin
        acc_next     = acc;
        acc_ovf_next = acc_ovf;
        if ((state == ST_MEASURE) && edge_p) begin
            if (acc == COUNT_MAX) begin
                acc_ovf_next = 1'b1;
            end else begin
                acc_next = acc + COUNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            gate_cap   <= '0;
            gate_cnt   <= '0;
            acc        <= '0;
            acc_ovf    <= 1'b0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
            gate_cap   <= gate_len;
            acc        <= '0;
            acc_ovf    <= 1'b0;
        end else begin
            if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
            if (load_gate) begin
                gate_cnt <= gate_cap;
            end else if (state == ST_MEASURE) begin
                gate_cnt <= gate_cnt - GATE_W'(1);
            end
            acc     <= acc_next;
            acc_ovf <= acc_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded on entry to DONE so they are valid in the
    // cycle done is high; untouched by abort.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (result_ld) begin
            count    <= acc_next;
            overflow <= acc_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register (async reset clears them)
    // ------------------------------------------------------------------
    assign busy      = (state == ST_SETTLE) || (state == ST_MEASURE);
    assign ro_en     = busy;
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ro_freq_counter.sv
// ----------------------------------------------------------------------------
// tb_ro_freq_counter
// Two instances share start/abort/gate_len/ro_clk and run in lockstep: the
// default one (COUNT_W=16) and a 4-bit one for saturation. The oscillator
// model toggles ro_clk every `half` clk cycles while ro_en is high and logs
// the clk cycle of every rise. Expected counts are the rises whose
// synchronized pulse (two cycles later) lands inside the gate window, with
// +/-1 tolerance for sampling phase.
// ----------------------------------------------------------------------------
module tb_ro_freq_counter;
    import ro_meas_pkg::*;

    localparam int S  = 8;
    localparam int CW = 16;
    localparam int GW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [GW-1:0] gate_len = '0;
    logic          ro_clk = 1'b0;

    logic          ro_en, busy, done, overflow;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;
    logic          ro_en4, busy4, done4, overflow4;
    logic [3:0]    count4;
    logic [1:0]    dbg_state4;

    ro_freq_counter #(.COUNT_W(CW), .GATE_W(GW), .SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .ro_clk(ro_clk), .ro_en(ro_en), .busy(busy),
        .done(done), .count(count), .overflow(overflow), .dbg_state(dbg_state)
    );

    ro_freq_counter #(.COUNT_W(4), .GATE_W(GW), .SETTLE_CYCLES(S)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gate_len(gate_len), .ro_clk(ro_clk), .ro_en(ro_en4), .busy(busy4),
        .done(done4), .count(count4), .overflow(overflow4), .dbg_state(dbg_state4)
    );

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- oscillator model ----------------
    int half = 4;
    int ph = 0;
    int rise_q[$];

    always @(posedge clk) begin
        #2;
        if (!ro_en) begin
            ph = 0;
            ro_clk = 1'b0;
        end else begin
            ph = ph + 1;
            if (ph >= half) begin
                ph = 0;
                ro_clk = ~ro_clk;
                if (ro_clk) rise_q.push_back(cyc);
            end
        end
    end

    // Rises whose synchronized pulse falls in MEASURE cycles T+S+1 .. T+S+g.
    function automatic int model_edges(input int t, input int g);
        int n = 0;
        foreach (rise_q[i]) begin
            if ((rise_q[i] + 2 >= t + S + 1) && (rise_q[i] + 2 <= t + S + g)) n++;
        end
        return n;
    endfunction

    // ---------------- driver ----------------
    int          r_start, r_done, r_overlap;
    bit          r_saw_measure;
    logic [CW-1:0] r_count;
    logic        r_ovf, r_ovf4, r_ro_en_done, r_busy_done;
    logic [3:0]  r_count4;

    // One measurement; optionally pulses start again pulse_at cycles after T.
    task automatic run_measure(input int g, input int hp, input int pulse_at);
        @(negedge clk);
        gate_len = GW'(g);
        half = hp;
        rise_q.delete();
        start = 1'b1;
        r_start = cyc;
        r_done = -1;
        r_overlap = 0;
        r_saw_measure = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < S + g + 40; i++) begin
            if (busy && done) r_overlap++;
            if (dbg_state == ST_MEASURE) r_saw_measure = 1;
            if (done) begin
                r_done = cyc;
                r_count = count;
                r_ovf = overflow;
                r_count4 = count4;
                r_ovf4 = overflow4;
                r_ro_en_done = ro_en;
                r_busy_done = busy;
                break;
            end
            start = (pulse_at >= 0 && cyc == r_start + pulse_at) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ro_en, busy, done, overflow} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {ro_en, busy, done, overflow});
        end
        checks++;
        if (count !== '0 || count4 !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d/%0d exp=0", count, count4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || ro_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle state=%0d ro_en=%b exp state=0 ro_en=0", dbg_state, ro_en);
        end
    endtask

    task automatic test_basic;
        int exp;
        run_measure(64, 4, -1);
        exp = model_edges(r_start, 64);
        checks++;
        if (r_done - r_start != S + 64 + 1) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=%0d", r_done - r_start, S + 65);
        end
        checks++;
        if (int'(r_count) > exp + 1 || int'(r_count) < exp - 1 || int'(r_count) > 9 || int'(r_count) < 7) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d(+/-1, nominal 8)", r_count, exp);
        end
        checks++;
        if (r_ovf !== 1'b0) begin
            failures++;
            $display("FAIL basic_overflow got=%b exp=0", r_ovf);
        end
        checks++;
        if (r_ro_en_done !== 1'b0 || r_busy_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_cycle ro_en=%b busy=%b exp 0 0", r_ro_en_done, r_busy_done);
        end
        checks++;
        if (r_overlap != 0) begin
            failures++;
            $display("FAIL basic_busy_done_overlap got=%0d exp=0", r_overlap);
        end
    endtask

    task automatic test_gate_zero;
        run_measure(0, 4, -1);
        checks++;
        if (r_done - r_start != S + 1) begin
            failures++;
            $display("FAIL gate0_latency got=%0d exp=%0d", r_done - r_start, S + 1);
        end
        checks++;
        if (r_count !== '0 || r_ovf !== 1'b0) begin
            failures++;
            $display("FAIL gate0_result count=%0d ovf=%b exp 0 0", r_count, r_ovf);
        end
        checks++;
        if (r_saw_measure) begin
            failures++;
            $display("FAIL gate0_no_measure got=1 exp=0");
        end
    endtask

    task automatic test_overflow;
        int exp;
        run_measure(200, 2, -1);
        exp = model_edges(r_start, 200);
        checks++;
        if (r_count4 !== 4'd15 || r_ovf4 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_saturate count4=%0d ovf4=%b exp 15 1", r_count4, r_ovf4);
        end
        checks++;
        if (int'(r_count) > exp + 1 || int'(r_count) < exp - 1 || r_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wide count=%0d ovf=%b exp %0d(+/-1) 0", r_count, r_ovf, exp);
        end
        run_measure(16, 2, -1);
        exp = model_edges(r_start, 16);
        checks++;
        if (r_ovf4 !== 1'b0 || int'(r_count4) > exp + 1 || int'(r_count4) < exp - 1) begin
            failures++;
            $display("FAIL ovf_clear count4=%0d ovf4=%b exp %0d(+/-1) 0", r_count4, r_ovf4, exp);
        end
    endtask

    task automatic test_abort;
        logic [CW-1:0] prev;
        logic [3:0]    prev4;
        int            t, dones;
        run_measure(64, 4, -1);
        prev = r_count;
        prev4 = r_count4;
        @(negedge clk);
        gate_len = GW'(64);
        half = 4;
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && cyc < t + S + 10; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ro_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_ro_en ro_en=%b busy=%b exp 0 0", ro_en, busy);
        end
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            if (done || done4) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        checks++;
        if (count !== prev || count4 !== prev4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold count=%0d/%0d ovf=%b exp %0d/%0d 0", count, count4, overflow, prev, prev4);
        end
    endtask

    task automatic test_start_while_busy;
        int exp;
        run_measure(40, 3, 20);
        exp = model_edges(r_start, 40);
        checks++;
        if (r_done - r_start != S + 40 + 1) begin
            failures++;
            $display("FAIL busy_start_latency got=%0d exp=%0d", r_done - r_start, S + 41);
        end
        checks++;
        if (int'(r_count) > exp + 1 || int'(r_count) < exp - 1) begin
            failures++;
            $display("FAIL busy_start_count got=%0d exp=%0d(+/-1)", r_count, exp);
        end
    endtask

    task automatic test_back_to_back;
        int t0, n;
        int td[3];
        @(negedge clk);
        gate_len = GW'(20);
        half = 3;
        start = 1'b1;
        t0 = cyc;
        n = 0;
        for (int i = 0; i < 3 * (S + 22) + 30 && n < 3; i++) begin
            @(negedge clk);
            if (done) begin
                td[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=3", n);
        end else begin
            checks++;
            if (td[0] - t0 != S + 21) begin
                failures++;
                $display("FAIL b2b_first got=%0d exp=%0d", td[0] - t0, S + 21);
            end
            checks++;
            if (td[1] - td[0] != S + 22 || td[2] - td[1] != S + 22) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", td[1] - td[0], td[2] - td[1], S + 22);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        logic [CW-1:0] exp_q[$];
        int g, hp, e;
        logic [CW-1:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            g = $urandom_range(80, 1);
            hp = $urandom_range(6, 2);
            run_measure(g, hp, -1);
            exp_q.push_back(CW'(model_edges(r_start, g)));
            checks++;
            if (r_done - r_start != S + g + 1) begin
                failures++;
                $display("FAIL rand_latency run=%0d gate=%0d got=%0d exp=%0d", k, g, r_done - r_start, S + g + 1);
            end
            exp_v = exp_q.pop_front();
            e = int'(exp_v);
            checks++;
            if (int'(r_count) > e + 1 || int'(r_count) < e - 1 || r_ovf !== 1'b0) begin
                failures++;
                $display("FAIL rand_count run=%0d gate=%0d half=%0d got=%0d ovf=%b exp=%0d(+/-1) 0", k, g, hp, r_count, r_ovf, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int t;
        run_measure(64, 4, -1);
        @(negedge clk);
        gate_len = GW'(64);
        half = 4;
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && cyc < t + S + 20; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ro_en, busy, done, overflow, ro_en4, busy4, overflow4} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid_flags got=%b exp=0000000", {ro_en, busy, done, overflow, ro_en4, busy4, overflow4});
        end
        checks++;
        if (count !== '0 || count4 !== '0) begin
            failures++;
            $display("FAIL rst_mid_count got=%0d/%0d exp=0", count, count4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE || ro_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle state=%0d ro_en=%b exp 0 0", dbg_state, ro_en);
        end
        run_measure(64, 4, -1);
        checks++;
        if (r_done - r_start != S + 65) begin
            failures++;
            $display("FAIL rst_mid_rerun got=%0d exp=%0d", r_done - r_start, S + 65);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_gate_zero();
        test_overflow();
        test_abort();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
